// File: rtl/capture_pkg.sv
// rtl/capture_pkg.sv - shared widths, parameter defaults and FSM state type for capture_ctrl
package capture_pkg;

    localparam int DATA_W           = 8;
    localparam int ADDR_W           = 12;
    localparam int CAP_LEN_DEF      = 591;
    localparam int HOLDOFF_DEF      = 500_500;
    localparam int AUTO_TIMEOUT_DEF = 1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TRIG,
        ST_CAPTURE,
        ST_DONE,
        ST_HOLDOFF
    } cap_state_t;

endpackage

// File: rtl/capture_ctrl_if.sv
// rtl/capture_ctrl_if.sv - ADC input, control and buffer write bundle of capture_ctrl
interface capture_ctrl_if;
    import capture_pkg::*;

    logic [DATA_W-1:0] adc_data;
    logic              adc_data_valid;
    logic              arm;
    logic              cont_mode;
    logic              abort;
    logic [DATA_W-1:0] trig_level;
    logic              trig_slope;
    logic              rd_done;
    logic              buf_wr;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;
    logic              busy;
    logic              cap_done;
    logic              trig_auto;

    // master: the capture controller; slave: ADC front end, host and buffer reader
    modport master (
        input  adc_data, adc_data_valid, arm, cont_mode, abort,
               trig_level, trig_slope, rd_done,
        output buf_wr, buf_addr, buf_data, busy, cap_done, trig_auto
    );

    modport slave (
        output adc_data, adc_data_valid, arm, cont_mode, abort,
               trig_level, trig_slope, rd_done,
        input  buf_wr, buf_addr, buf_data, busy, cap_done, trig_auto
    );

endinterface

// File: rtl/trig_detect.sv
// rtl/trig_detect.sv - level/slope latch, two-sample history and edge compare
module trig_detect
    import capture_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              enable,
    input  logic              valid,
    input  logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] level_in,
    input  logic              slope_in,
    output logic              fire
);

    logic [DATA_W-1:0] level;
    logic              slope;
    logic [DATA_W-1:0] prev;
    logic              have_prev;

    // start latches the threshold and forgets history so an edge needs two fresh samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level     <= '0;
            slope     <= 1'b0;
            prev      <= '0;
            have_prev <= 1'b0;
        end else if (start) begin
            level     <= level_in;
            slope     <= slope_in;
            prev      <= '0;
            have_prev <= 1'b0;
        end else if (enable && valid) begin
            prev      <= data;
            have_prev <= 1'b1;
        end
    end

    always_comb begin
        fire = 1'b0;
        if (enable && valid && have_prev) begin
            if (slope)
                fire = (prev >= level) && (data < level);
            else
                fire = (prev < level) && (data >= level);
        end
    end

endmodule

// File: rtl/capture_ctrl.sv
// rtl/capture_ctrl.sv - triggered ADC capture FSM writing CAP_LEN samples to a buffer
// Optional macro AUTO_TRIG_EN adds the auto-trigger timeout.
module capture_ctrl
    import capture_pkg::*;
#(
    parameter int CAP_LEN      = CAP_LEN_DEF,
    parameter int HOLDOFF      = HOLDOFF_DEF,
    parameter int AUTO_TIMEOUT = AUTO_TIMEOUT_DEF
) (
    input logic            adc_clk,
    input logic            rst,
    capture_ctrl_if.master bus
);

    localparam int HO_W = $clog2(HOLDOFF + 1);

    if (CAP_LEN < 2 || CAP_LEN > 4096 || HOLDOFF < 1 || AUTO_TIMEOUT < 1) begin : g_param_check
        $error("capture_ctrl: parameter out of range");
    end

    cap_state_t        state;
    logic [ADDR_W-1:0] wr_idx;
    logic [HO_W-1:0]   ho_cnt;
    logic              in_wait;
    logic              ho_last;
    logic              start;
    logic              edge_fire;
    logic              force_trig;
    logic              fire_any;

    assign in_wait  = (state == ST_WAIT_TRIG);
    assign ho_last  = (state == ST_HOLDOFF) && (ho_cnt == HO_W'(HOLDOFF - 1));
    assign start    = !bus.abort && (((state == ST_IDLE) && bus.arm) || (ho_last && bus.cont_mode));
    assign fire_any = edge_fire || force_trig;

    trig_detect u_trig (
        .clk      (adc_clk),
        .rst      (rst),
        .start    (start),
        .enable   (in_wait),
        .valid    (bus.adc_data_valid),
        .data     (bus.adc_data),
        .level_in (bus.trig_level),
        .slope_in (bus.trig_slope),
        .fire     (edge_fire)
    );

`ifdef AUTO_TRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt;
    logic            timed_out;

    assign timed_out  = (to_cnt == TO_W'(AUTO_TIMEOUT));
    assign force_trig = in_wait && bus.adc_data_valid && timed_out && !edge_fire;

    // saturates at the timeout so a long invalid stretch cannot wrap it
    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            to_cnt        <= '0;
            bus.trig_auto <= 1'b0;
        end else if (bus.abort) begin
            to_cnt <= '0;
        end else if (start) begin
            to_cnt        <= '0;
            bus.trig_auto <= 1'b0;
        end else if (in_wait) begin
            if (force_trig) begin
                to_cnt        <= '0;
                bus.trig_auto <= 1'b1;
            end else if (!timed_out) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end
`else
    assign force_trig    = 1'b0;
    assign bus.trig_auto = 1'b0;
`endif

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            wr_idx       <= '0;
            ho_cnt       <= '0;
            bus.buf_wr   <= 1'b0;
            bus.buf_addr <= '0;
            bus.buf_data <= '0;
            bus.busy     <= 1'b0;
            bus.cap_done <= 1'b0;
        end else begin
            bus.buf_wr <= 1'b0;
            if (bus.abort) begin
                state        <= ST_IDLE;
                wr_idx       <= '0;
                ho_cnt       <= '0;
                bus.busy     <= 1'b0;
                bus.cap_done <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.arm) begin
                            state    <= ST_WAIT_TRIG;
                            bus.busy <= 1'b1;
                        end
                    end
                    ST_WAIT_TRIG: begin
                        if (fire_any) begin
                            bus.buf_wr   <= 1'b1;
                            bus.buf_addr <= '0;
                            bus.buf_data <= bus.adc_data;
                            wr_idx       <= ADDR_W'(1);
                            state        <= ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (bus.adc_data_valid) begin
                            bus.buf_wr   <= 1'b1;
                            bus.buf_addr <= wr_idx;
                            bus.buf_data <= bus.adc_data;
                            if (wr_idx == ADDR_W'(CAP_LEN - 1)) begin
                                wr_idx       <= '0;
                                state        <= ST_DONE;
                                bus.cap_done <= 1'b1;
                            end else begin
                                wr_idx <= wr_idx + ADDR_W'(1);
                            end
                        end
                    end
                    ST_DONE: begin
                        if (bus.rd_done) begin
                            state        <= ST_HOLDOFF;
                            ho_cnt       <= '0;
                            bus.cap_done <= 1'b0;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (ho_last) begin
                            ho_cnt <= '0;
                            if (bus.cont_mode) begin
                                state <= ST_WAIT_TRIG;
                            end else begin
                                state    <= ST_IDLE;
                                bus.busy <= 1'b0;
                            end
                        end else begin
                            ho_cnt <= ho_cnt + HO_W'(1);
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/capture_ctrl.md
CAPTURE_CTRL -- requirements
Module: capture_ctrl

Interface
REQ-001 Parameter CAP_LEN, default 591, SHALL set the samples written per capture (range 2..4096).
REQ-002 Parameter HOLDOFF, default 500_500, SHALL set the adc_clk cycles spent in HOLDOFF after each readout.
REQ-003 Parameter AUTO_TIMEOUT, default 1_000_000, SHALL set the auto-trigger timeout in cycles; it is used only with AUTO_TRIG_EN.
REQ-004 adc_clk  in  1  SHALL be the sole clock; all logic is rising-edge.
REQ-005 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-006 adc_data  in  8  SHALL be the unsigned ADC sample.
REQ-007 adc_data_valid  in  1  SHALL qualify adc_data for the current cycle.
REQ-008 arm  in  1  SHALL be a single-cycle pulse that starts an acquisition.
REQ-009 cont_mode  in  1  SHALL select re-arm after holdoff (1) or return to idle (0).
REQ-010 abort  in  1  SHALL be a single-cycle pulse that cancels any acquisition.
REQ-011 trig_level  in  8  SHALL be the trigger threshold.
REQ-012 trig_slope  in  1  SHALL select the trigger edge: 0 is rising, 1 is falling.
REQ-013 rd_done  in  1  SHALL be a single-cycle pulse from the buffer reader indicating the readout is complete.
REQ-014 buf_wr  out  1  SHALL be the buffer write strobe.
REQ-015 buf_addr  out  12  SHALL be the buffer write address.
REQ-016 buf_data  out  8  SHALL be the buffer write data.
REQ-017 busy  out  1  SHALL be high in every state except IDLE.
REQ-018 cap_done  out  1  SHALL be high only in DONE.
REQ-019 trig_auto  out  1  SHALL be high when the current or last capture was auto-triggered.

Function
REQ-020 The FSM SHALL have the states IDLE, WAIT_TRIG, CAPTURE, DONE and HOLDOFF.
REQ-021 In IDLE, an arm pulse SHALL move the FSM to WAIT_TRIG; arm SHALL be ignored in every other state.
REQ-022 On entry to WAIT_TRIG, the history register SHALL clear, and a trigger SHALL require two valid samples seen in WAIT_TRIG.
REQ-023 Rising trigger SHALL fire when, on valid samples, prev < trig_level and cur >= trig_level; falling trigger SHALL fire when prev >= trig_level and cur < trig_level.
REQ-024 Invalid cycles SHALL neither update the history nor fire the trigger.
REQ-025 The triggering sample SHALL be written at address 0, and the FSM SHALL enter CAPTURE.
REQ-026 In CAPTURE, each valid sample SHALL be written at consecutive addresses; after address CAP_LEN-1 is written, the FSM SHALL enter DONE.
REQ-027 buf_wr, buf_addr and buf_data SHALL be registered, with buf_data equal to the sample from exactly one cycle earlier.
REQ-028 buf_wr SHALL be high for exactly CAP_LEN cycles per capture and SHALL NOT be high outside writes of valid samples.
REQ-029 buf_addr SHALL hold its last written value when buf_wr is low, and SHALL never exceed CAP_LEN-1 (no wrap).
REQ-030 DONE SHALL wait indefinitely for rd_done, then enter HOLDOFF; rd_done SHALL be ignored in every other state.
REQ-031 HOLDOFF SHALL last exactly HOLDOFF cycles, then go to WAIT_TRIG if cont_mode=1, else to IDLE.
REQ-032 cont_mode SHALL be sampled on the HOLDOFF exit cycle.
REQ-033 abort SHALL move the FSM to IDLE on the next edge from any state, clear the counters and force buf_wr low that cycle; abort SHALL take priority over arm, trigger and rd_done in the same cycle.
REQ-034 trig_level and trig_slope SHALL be sampled when arm is accepted and when HOLDOFF exits to WAIT_TRIG, and held until the next such point.
REQ-035 All counters SHALL be sized for their parameter and SHALL never overflow.

Reset
REQ-036 While rst is high, the FSM SHALL be in IDLE and all counters and history SHALL be 0.
REQ-037 While rst is high, buf_wr=0, buf_addr=0, buf_data=0, busy=0, cap_done=0 and trig_auto=0.
REQ-038 Reset asserted mid-capture SHALL abandon the capture, with no further writes after release until a new arm.

Configuration
REQ-039 With AUTO_TRIG_EN defined, WAIT_TRIG SHALL force a trigger on the first valid sample after AUTO_TIMEOUT cycles without an edge trigger, write that sample at address 0, and set trig_auto.
REQ-040 trig_auto SHALL clear on the next entry to WAIT_TRIG.
REQ-041 Without AUTO_TRIG_EN, the timeout counter SHALL be absent, WAIT_TRIG SHALL wait indefinitely, and trig_auto SHALL be tied to 0.

Structure
REQ-042 Package capture_pkg SHALL hold the state enum, the data and address widths, and the parameter defaults.
REQ-043 Sub-module trig_detect SHALL hold the history register, the level/slope latch and the edge compare, with a 1-bit fire output.

Verification
REQ-044 Rising ramp 0..255 with valid=1, trig_level=127, trig_slope=0, arm: the first write SHALL be addr 0 with data 127, followed by 591 writes in total, then cap_done=1.
REQ-045 Falling ramp with trig_slope=1, trig_level=100, and valid toggled every other cycle: the trigger SHALL fire on the first valid sample <100, and addresses SHALL advance only on valid samples.
REQ-046 After a capture, pulse rd_done with cont_mode=1 and HOLDOFF=10: WAIT_TRIG SHALL be re-entered exactly 10 cycles later; repeating with cont_mode=0 SHALL reach IDLE with busy=0.
REQ-047 abort pulsed at sample 300 of a capture: buf_wr SHALL be 0 from the next cycle, the FSM SHALL be in IDLE, and the next arm SHALL restart at addr 0.
REQ-048 With AUTO_TRIG_EN, AUTO_TIMEOUT=50, and constant adc_data=20: a forced capture SHALL begin after 50 cycles with trig_auto=1; without the macro, no write SHALL occur within 1000 cycles.
